// File: rtl/tt_um_michaelbell_spi_peri.sv
// SPI mode-0 peripheral with a 16 x 8 register file, single and quad reads,
// and a seven-segment view of any register nibble for on-board debugging.
module tt_um_michaelbell_spi_peri (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, WRITE, READ, QREAD} state_t;
  typedef enum logic [1:0] {MODE_WRITE, MODE_READ, MODE_QREAD} mode_t;

  state_t     r_state;
  mode_t      r_mode;
  logic [1:0] r_sckSync, r_csSync, r_mosiSync;
  logic       r_sckPrev, r_armed, r_qActive, r_nibLow, r_dbgSel;
  logic [2:0] r_bitCnt;
  logic [7:0] r_shift;
  logic [3:0] r_addr, r_dbgAddr, r_dataOut;
  logic [7:0] r_mem [16];

  logic       w_csHigh, w_sckRise, w_sckFall, w_unused;
  logic [7:0] w_byteIn, w_rdByte;
  logic [2:0] w_bitSel;
  logic [3:0] w_dbgData;
  logic [6:0] w_seg;

  assign w_csHigh  = r_csSync[1];
  assign w_sckRise = r_sckSync[1] & ~r_sckPrev;
  assign w_sckFall = ~r_sckSync[1] & r_sckPrev;
  assign w_byteIn  = {r_shift[6:0], r_mosiSync[1]};
  assign w_rdByte  = r_mem[r_addr];
  assign w_bitSel  = 3'd7 - r_bitCnt;
  assign w_dbgData = r_dbgSel ? r_mem[r_dbgAddr][7:4] : r_mem[r_dbgAddr][3:0];
  assign w_unused  = &{1'b0, ena, ui_in[7], uio_in[7:1]};

  always_comb begin
    w_seg = 7'h00;
    case (w_dbgData)
      4'h0: w_seg = 7'h3F;
      4'h1: w_seg = 7'h06;
      4'h2: w_seg = 7'h5B;
      4'h3: w_seg = 7'h4F;
      4'h4: w_seg = 7'h66;
      4'h5: w_seg = 7'h6D;
      4'h6: w_seg = 7'h7D;
      4'h7: w_seg = 7'h07;
      4'h8: w_seg = 7'h7F;
      4'h9: w_seg = 7'h6F;
      4'hA: w_seg = 7'h77;
      4'hB: w_seg = 7'h7C;
      4'hC: w_seg = 7'h39;
      4'hD: w_seg = 7'h5E;
      4'hE: w_seg = 7'h79;
      default: w_seg = 7'h71;
    endcase
  end

  assign uo_out  = {~r_csSync[1], w_seg};
  assign uio_out = {w_dbgData, r_dataOut};
  assign uio_oe  = r_qActive ? 8'hFF : 8'hF2;

  // The CS synchronizer resets to "low" and r_armed only sets once CS is seen
  // high, so a transaction cut by reset never resumes until CS cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_mode     <= MODE_WRITE;
      r_sckSync  <= 2'b00;
      r_csSync   <= 2'b00;
      r_mosiSync <= 2'b00;
      r_sckPrev  <= 1'b0;
      r_armed    <= 1'b0;
      r_qActive  <= 1'b0;
      r_nibLow   <= 1'b0;
      r_dbgSel   <= 1'b0;
      r_dbgAddr  <= 4'h0;
      r_bitCnt   <= 3'd0;
      r_shift    <= 8'h00;
      r_addr     <= 4'h0;
      r_dataOut  <= 4'h0;
      for (int i = 0; i < 16; i++) r_mem[i] <= 8'h00;
    end else begin
      r_sckSync  <= {r_sckSync[0], ui_in[0]};
      r_csSync   <= {r_csSync[0], ui_in[1]};
      r_mosiSync <= {r_mosiSync[0], uio_in[0]};
      r_sckPrev  <= r_sckSync[1];
      r_dbgAddr  <= ui_in[5:2];
      r_dbgSel   <= ui_in[6];
      if (w_csHigh) begin
        r_state   <= IDLE;
        r_armed   <= 1'b1;
        r_qActive <= 1'b0;
        r_dataOut <= 4'h0;
      end else begin
        case (r_state)
          IDLE: begin
            if (r_armed) begin
              r_state  <= CMD;
              r_armed  <= 1'b0;
              r_bitCnt <= 3'd0;
            end
          end
          CMD: begin
            if (w_sckRise) begin
              r_shift  <= w_byteIn;
              r_bitCnt <= r_bitCnt + 3'd1;
              if (r_bitCnt == 3'd7) begin
                case (w_byteIn)
                  8'h02: begin r_mode <= MODE_WRITE; r_state <= ADDR; end
                  8'h03: begin r_mode <= MODE_READ;  r_state <= ADDR; end
                  8'h6B: begin r_mode <= MODE_QREAD; r_state <= ADDR; end
                  default: r_state <= IDLE;
                endcase
              end
            end
          end
          ADDR: begin
            if (w_sckRise) begin
              r_shift  <= w_byteIn;
              r_bitCnt <= r_bitCnt + 3'd1;
              if (r_bitCnt == 3'd7) begin
                r_addr   <= w_byteIn[3:0];
                r_nibLow <= 1'b0;
                case (r_mode)
                  MODE_READ:  r_state <= READ;
                  MODE_QREAD: r_state <= QREAD;
                  default:    r_state <= WRITE;
                endcase
              end
            end
          end
          WRITE: begin
            if (w_sckRise) begin
              r_shift  <= w_byteIn;
              r_bitCnt <= r_bitCnt + 3'd1;
              if (r_bitCnt == 3'd7) begin
                r_mem[r_addr] <= w_byteIn;
                r_addr        <= r_addr + 4'd1;
              end
            end
          end
          READ: begin
            if (w_sckFall) begin
              r_dataOut <= {2'b00, w_rdByte[w_bitSel], 1'b0};
              r_bitCnt  <= r_bitCnt + 3'd1;
              if (r_bitCnt == 3'd7) r_addr <= r_addr + 4'd1;
            end
          end
          QREAD: begin
            if (w_sckFall) begin
              r_qActive <= 1'b1;
              r_nibLow  <= ~r_nibLow;
              r_dataOut <= r_nibLow ? w_rdByte[3:0] : w_rdByte[7:4];
              if (r_nibLow) r_addr <= r_addr + 4'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tt_um_michaelbell_spi_peri.sv
// Self-checking bench: drives SPI transactions bit by bit and compares the
// pins against a byte-array model of the register file.
module tb_tt_um_michaelbell_spi_peri;
  logic       clk, rst_n, ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int total = 0;
  int bad = 0;
  logic [7:0] model [16];
  logic [7:0] txQ [$];
  logic [3:0] nibQ [$];
  logic [7:0] oeQ [$];

  tt_um_michaelbell_spi_peri dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] hexSeg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic setCs(input logic level);
    ui_in[1] = level;
    repeat (4) @(negedge clk);
  endtask

  // Bits are taken MSB first from txQ (zero padded); pin samples are taken
  // just before each rising SCK edge, i.e. what a mode-0 master would see.
  task automatic applyStimulus(input int nBits, input logic endCs);
    logic [7:0] b;
    nibQ.delete();
    oeQ.delete();
    setCs(1'b0);
    for (int i = 0; i < nBits; i++) begin
      b = (i / 8 < txQ.size()) ? txQ[i / 8] : 8'h00;
      uio_in[0] = b[7 - (i % 8)];
      repeat (4) @(negedge clk);
      nibQ.push_back(uio_out[3:0]);
      oeQ.push_back(uio_oe);
      ui_in[0] = 1'b1;
      repeat (4) @(negedge clk);
      ui_in[0] = 1'b0;
    end
    repeat (4) @(negedge clk);
    if (endCs) setCs(1'b1);
  endtask

  task automatic checkMemory(input int a);
    logic [3:0] nib;
    for (int sel = 0; sel < 2; sel++) begin
      ui_in[5:2] = 4'(a);
      ui_in[6]   = (sel == 1);
      repeat (3) @(negedge clk);
      nib = (sel == 1) ? model[a][7:4] : model[a][3:0];
      checkOutput($sformatf("dbg data a=%0d sel=%0d", a, sel), {4'h0, uio_out[7:4]}, {4'h0, nib});
      checkOutput($sformatf("dbg seg a=%0d sel=%0d", a, sel), {1'b0, uo_out[6:0]}, {1'b0, hexSeg(nib)});
    end
  endtask

  task automatic checkAllMemory();
    for (int a = 0; a < 16; a++) checkMemory(a);
  endtask

  task automatic writeBurst(input logic [3:0] a, input int n);
    logic [7:0] addrByte, d;
    addrByte = 8'($urandom_range(0, 255));
    addrByte[3:0] = a;
    txQ = '{8'h02, addrByte};
    for (int k = 0; k < n; k++) begin
      d = 8'($urandom_range(0, 255));
      txQ.push_back(d);
      model[(int'(a) + k) % 16] = d;
    end
    applyStimulus(16 + 8 * n, 1'b1);
  endtask

  task automatic readBurst(input logic [3:0] a, input int n, input string tag);
    logic [7:0] got, oeSeen, addrByte;
    addrByte = 8'($urandom_range(0, 255));
    addrByte[3:0] = a;
    txQ = '{8'h03, addrByte};
    applyStimulus(16 + 8 * n, 1'b1);
    for (int k = 0; k < n; k++) begin
      got = 8'h00;
      for (int j = 0; j < 8; j++) got = {got[6:0], nibQ[16 + 8 * k + j][1]};
      checkOutput($sformatf("%s byte%0d", tag, k), got, model[(int'(a) + k) % 16]);
    end
    oeSeen = 8'hF2;
    foreach (oeQ[i]) if (oeQ[i] !== 8'hF2) oeSeen = oeQ[i];
    checkOutput($sformatf("%s oe", tag), oeSeen, 8'hF2);
  endtask

  task automatic quadBurst(input logic [3:0] a, input int nNib, input string tag);
    logic [7:0] oeSeen, cur;
    txQ = '{8'h6B, {4'h0, a}};
    applyStimulus(16 + nNib, 1'b0);
    for (int i = 0; i < nNib; i++) begin
      cur = model[(int'(a) + i / 2) % 16];
      checkOutput($sformatf("%s nib%0d", tag, i), {4'h0, nibQ[16 + i]},
                  {4'h0, (i % 2 == 0) ? cur[7:4] : cur[3:0]});
    end
    oeSeen = 8'hFF;
    for (int i = 16; i < 16 + nNib; i++) if (oeQ[i] !== 8'hFF) oeSeen = oeQ[i];
    checkOutput($sformatf("%s oe data", tag), oeSeen, 8'hFF);
    setCs(1'b1);
    checkOutput($sformatf("%s oe after", tag), uio_oe, 8'hF2);
    checkOutput($sformatf("%s out after", tag), {4'h0, uio_out[3:0]}, 8'h00);
  endtask

  initial begin
    logic [3:0] nz;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h02;
    uio_in = 8'h00;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset oe", uio_oe, 8'hF2);
    checkOutput("reset out", {4'h0, uio_out[3:0]}, 8'h00);
    checkOutput("reset seg", {1'b0, uo_out[6:0]}, 8'h3F);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkAllMemory();

    setCs(1'b0);
    checkOutput("dot cs low", {7'h0, uo_out[7]}, 8'h01);
    setCs(1'b1);
    checkOutput("dot cs high", {7'h0, uo_out[7]}, 8'h00);

    txQ = '{8'h02, 8'h05, 8'hA5, 8'h3C};
    applyStimulus(32, 1'b1);
    model[5] = 8'hA5;
    model[6] = 8'h3C;
    ui_in[5:2] = 4'h5;
    ui_in[6]   = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("write dbg A", {4'h0, uio_out[7:4]}, 8'h0A);
    checkOutput("write seg A", {1'b0, uo_out[6:0]}, 8'h77);
    checkMemory(6);

    readBurst(4'h5, 2, "read 05");

    txQ = '{8'h02, 8'h0F, 8'h11, 8'h22};
    applyStimulus(32, 1'b1);
    model[15] = 8'h11;
    model[0]  = 8'h22;
    readBurst(4'hF, 2, "read wrap");

    quadBurst(4'h5, 4, "quad 05");

    txQ = '{8'h02, 8'h03, 8'hE7};
    applyStimulus(20, 1'b1);
    checkMemory(3);
    txQ = '{8'hFF, 8'h12, 8'h34, 8'h56};
    applyStimulus(32, 1'b1);
    nz = 4'h0;
    foreach (nibQ[i]) nz = nz | nibQ[i];
    checkOutput("bad cmd out", {4'h0, nz}, 8'h00);
    checkAllMemory();

    for (int it = 0; it < 6; it++) begin
      writeBurst(4'($urandom_range(0, 15)), $urandom_range(1, 4));
      readBurst(4'($urandom_range(0, 15)), 3, $sformatf("rand read %0d", it));
      quadBurst(4'($urandom_range(0, 15)), 4, $sformatf("rand quad %0d", it));
    end
    checkAllMemory();

    txQ = '{8'h6B, 8'h00};
    applyStimulus(18, 1'b0);
    checkOutput("mid quad oe", uio_oe, 8'hFF);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset oe", uio_oe, 8'hF2);
    checkOutput("async reset out", {4'h0, uio_out[3:0]}, 8'h00);
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    txQ = '{8'h02, 8'h04, 8'h77};
    applyStimulus(24, 1'b0);
    checkMemory(4);
    setCs(1'b1);
    writeBurst(4'h4, 1);
    checkAllMemory();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tt_um_michaelbell_spi_peri.md
TT_UM_MICHAELBELL_SPI_PERI -- requirements
Module: tt_um_michaelbell_spi_peri

Interface
REQ-001 SHALL have one clock, clk (input, 1): system clock that oversamples the SPI pins.
REQ-002 SHALL have rst_n (input, 1): asynchronous, active-low reset.
REQ-003 SHALL have ena (input, 1): design-selected flag, ignored functionally.
REQ-004 SHALL use ui_in (input, 8) as: [0] SPI SCK, [1] SPI CS_n (active low), [5:2] debug_addr, [6] debug nibble select (0 = low, 1 = high), [7] unused.
REQ-005 SHALL use uio_in (input, 8) as: [0] MOSI; [7:1] ignored.
REQ-006 SHALL use uo_out (output, 8) as: [6:0] seven-segment a..g, active high; [7] dot.
REQ-007 SHALL use uio_out (output, 8) as: [1] MISO in single mode, [3:0] quad data in quad mode, [7:4] debug_data.
REQ-008 SHALL drive uio_oe (output, 8): 8'hF2 normally; 8'hFF only during a quad-read data phase.

Function
REQ-009 SHALL pass SCK, CS_n and MOSI through 2-flop synchronizers on clk; SCK edges are detected on synchronized values; clk >= 4x SCK.
REQ-010 SHALL implement SPI mode 0, MSB first: sample MOSI on SCK rising edge; update MISO/quad outputs within 3 clk of SCK falling edge.
REQ-011 SHALL hold a 16 x 8-bit register file, 4-bit address, cleared to 0 on reset.
REQ-012 SHALL decode the first byte after CS_n falls as a command: 8'h02 write, 8'h03 read, 8'h6B quad read; any other value is ignored until CS_n rises, with outputs at 0.
REQ-013 SHALL take the second byte as the start address; bits [3:0] are used and [7:4] are ignored.
REQ-014 Write: each further complete byte SHALL be stored at the current address, then the address increments.
REQ-015 Read: from the SCK falling edge after the last address bit, SHALL shift out data[addr] MSB first on uio_out[1]; the address increments after each byte.
REQ-016 Quad read: from the SCK falling edge after the last address bit, SHALL set uio_oe = 8'hFF and output one nibble per SCK on uio_out[3:0], high nibble first; the address increments every 2 nibbles.
REQ-017 SHALL wrap the address from 15 to 0 in all modes.
REQ-018 SHALL have states IDLE, CMD, ADDR, WRITE, READ, QREAD; CS_n high forces IDLE at any point.
REQ-019 If CS_n rises mid-byte, SHALL discard the partial write byte and not change memory.
REQ-020 SHALL hold MISO (and uio_out[3:0]) at 0 outside READ/QREAD.
REQ-021 SHALL drive debug_data = ui_in[6] ? mem[debug_addr][7:4] : mem[debug_addr][3:0], combinational from memory and registered inputs, updating continuously.
REQ-022 Segments SHALL show debug_data as a hex digit (0 -> 7'h3F, 1 -> 7'h06, 8 -> 7'h7F, A -> 7'h77, F -> 7'h71).
REQ-023 Dot SHALL be 1 while synchronized CS_n is low.
REQ-024 A memory write and a debug read of the same address in the same cycle SHALL show the old value, then the new value the next clk.

Reset
REQ-025 While rst_n is low, the block SHALL be in IDLE with memory all 0, uio_out[3:0] = 0, uio_oe = 8'hF2, and segments = 7'h3F (debug_data = 0).
REQ-026 Reset asserted mid-transaction SHALL abort it immediately; after release the block waits for CS_n high then low before decoding a command.

Verification
REQ-027 Reset, then debug_addr sweep over 0..15 -> debug_data = 0 and segments = 7'h3F for every address.
REQ-028 CS_n low, send 02 05 A5 3C, CS_n high -> mem[5] = A5 and mem[6] = 3C; debug_addr = 5 with ui_in[6] = 1 gives debug_data = A and segments = 7'h77.
REQ-029 After REQ-028, send 03 05 and clock 16 bits -> MISO bytes A5, 3C; uio_oe stays F2.
REQ-030 Write 02 0F 11 22 -> mem[15] = 11 and mem[0] = 22 (wrap); read 03 0F -> 11, 22.
REQ-031 After REQ-028, send 6B 05 and clock 4 SCK -> nibbles A, 5, 3, C on uio_out[3:0] with uio_oe = FF; after CS_n high, uio_oe = F2.
REQ-032 Send 02 03, then 4 bits of a data byte, then CS_n high -> mem[3] is unchanged; send FF and clock 16 bits -> MISO stays 0 and memory is unchanged.
